// File: rtl/dcache_refill_unit.sv
// Purpose: services one L1 data-cache miss by fetching a block over a narrow beat bus and returning it on the fill port.
// Latency: 1 (sample) + 1 (request) + BEATS (beats) + 1 (resolve) cycles minimum from miss to repair_resolved.
// Backpressure: request held until mem_req_ready; beats accepted only in FILL, gaps hold the beat counter.
module dcache_refill_unit #(
    parameter int BLOCK_BITS  = 1024,
    parameter int BEAT_BITS   = 32,
    parameter int OFFSET_BITS = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      read_repair_request,
    input  logic                      write_miss_repair,
    input  logic [31:0]               rd_miss_addr,
    input  logic [31:0]               wr_miss_addr,
    output logic                      repair_resolved,
    output logic [31:0]               fill_addr,
    output logic [BLOCK_BITS-1:0]     fill_data,
    output logic [BLOCK_BITS/8-1:0]   fill_mask,
    output logic                      busy,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [31:0]               mem_req_addr,
    input  logic                      mem_rsp_valid,
    input  logic [BEAT_BITS-1:0]      mem_rsp_data,
    output logic                      mem_rsp_ready
);

    localparam int BEATS = BLOCK_BITS / BEAT_BITS;
    localparam int CNT_W = $clog2(BEATS);
    localparam int BUF_W = BLOCK_BITS - BEAT_BITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           miss_addr;
    // Only the first BEATS-1 beats are staged; the last beat lands straight in fill_data.
    logic [BUF_W-1:0]      beat_buf;
    logic [BLOCK_BITS-1:0] fill_data_q;
    logic [31:0]           fill_addr_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_miss_addr[OFFSET_BITS-1:0], wr_miss_addr[OFFSET_BITS-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            miss_addr   <= '0;
            beat_buf    <= '0;
            fill_data_q <= '0;
            fill_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Read wins a tie; the dropped write miss is re-raised by the cache later.
                    if (read_repair_request) begin
                        miss_addr <= {rd_miss_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        state     <= S_REQ;
                    end else if (write_miss_repair) begin
                        miss_addr <= {wr_miss_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_rsp_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            fill_data_q <= {mem_rsp_data, beat_buf};
                            fill_addr_q <= miss_addr;
                            state       <= S_DONE;
                        end else begin
                            beat_buf[cnt*BEAT_BITS +: BEAT_BITS] <= mem_rsp_data;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy            = (state != S_IDLE);
    assign mem_req_valid   = (state == S_REQ);
    assign mem_req_addr    = mem_req_valid ? miss_addr : '0;
    assign mem_rsp_ready   = (state == S_FILL);
    assign repair_resolved = (state == S_DONE);
    assign fill_mask       = {(BLOCK_BITS/8){repair_resolved}};
    assign fill_data       = fill_data_q;
    assign fill_addr       = fill_addr_q;

endmodule
